// File: rtl/instruction_fetch_unit.sv
// Fetch stage of the 32-bit MIPS pipeline: owns the PC, addresses instruction memory
// and fills the IF/ID register, with stall, redirect, fault and debug-count handling.
`timescale 1ns/1ps
module instruction_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int unsigned IMEM_DEPTH = 128,
    parameter logic [31:0] NOP_INST   = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump,
    input  logic [31:0] jump_target,
    input  logic [31:0] imem_inst,
    output logic [31:0] imem_addr,
    output logic [31:0] pc,
    output logic [31:0] if_id_inst,
    output logic [31:0] if_id_pc4,
    output logic        if_id_valid,
    output logic        fetch_fault,
    output logic        misalign_err,
    output logic [31:0] fetch_count
);

    logic [31:0] pc_q, pc_d;
    logic [31:0] inst_q, inst_d;
    logic [31:0] pc4_q, pc4_d;
    logic        valid_q, valid_d;
    logic        fault_q, fault_d;
    logic        misalign_q, misalign_d;
    logic [31:0] count_q, count_d;

    logic [31:0] word_idx;
    logic [31:0] pc_plus4;
    logic        in_range;

    assign word_idx = {2'b00, pc_q[31:2]};
    assign pc_plus4 = pc_q + 32'd4;
    assign in_range = (word_idx < IMEM_DEPTH);

    // Priority: fault (terminal) > branch > jump > stall > sequential fetch.
    always_comb begin
        pc_d       = pc_q;
        inst_d     = inst_q;
        pc4_d      = pc4_q;
        valid_d    = valid_q;
        fault_d    = fault_q;
        misalign_d = misalign_q;
        count_d    = count_q;

        if (fault_q) begin
            inst_d  = NOP_INST;
            pc4_d   = '0;
            valid_d = 1'b0;
        end else if (branch_taken) begin
            pc_d    = {branch_target[31:2], 2'b00};
            inst_d  = NOP_INST;
            pc4_d   = '0;
            valid_d = 1'b0;
            if (branch_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (jump) begin
            pc_d    = {jump_target[31:2], 2'b00};
            inst_d  = NOP_INST;
            pc4_d   = '0;
            valid_d = 1'b0;
            if (jump_target[1:0] != 2'b00) begin
                misalign_d = 1'b1;
            end
        end else if (stall) begin
            pc_d = pc_q;
        end else if (!in_range) begin
            // PC freezes on the offending address so debug can see where it ran off.
            inst_d  = NOP_INST;
            pc4_d   = '0;
            valid_d = 1'b0;
            fault_d = 1'b1;
        end else begin
            pc_d    = pc_plus4;
            inst_d  = imem_inst;
            pc4_d   = pc_plus4;
            valid_d = 1'b1;
            count_d = count_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC;
            inst_q     <= NOP_INST;
            pc4_q      <= '0;
            valid_q    <= 1'b0;
            fault_q    <= 1'b0;
            misalign_q <= 1'b0;
            count_q    <= '0;
        end else begin
            pc_q       <= pc_d;
            inst_q     <= inst_d;
            pc4_q      <= pc4_d;
            valid_q    <= valid_d;
            fault_q    <= fault_d;
            misalign_q <= misalign_d;
            count_q    <= count_d;
        end
    end

    assign imem_addr    = word_idx;
    assign pc           = pc_q;
    assign if_id_inst   = inst_q;
    assign if_id_pc4    = pc4_q;
    assign if_id_valid  = valid_q;
    assign fetch_fault  = fault_q;
    assign misalign_err = misalign_q;
    assign fetch_count  = count_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scoreboard bench for instruction_fetch_unit: expected IF/ID/PC state is queued when
// stimulus is applied and compared after the clock edge that should produce it.
`timescale 1ns/1ps
module tb_instruction_fetch_unit;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
        logic [31:0] pc4;
        logic [31:0] cnt;
        logic        valid;
        logic        fault;
        logic        mis;
    } st_t;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = '0;
    logic        jump = 1'b0;
    logic [31:0] jump_target = '0;
    logic [31:0] imem_inst;
    logic [31:0] imem_addr;
    logic [31:0] pc;
    logic [31:0] if_id_inst;
    logic [31:0] if_id_pc4;
    logic        if_id_valid;
    logic        fetch_fault;
    logic        misalign_err;
    logic [31:0] fetch_count;

    logic [31:0] mem [0:127];
    st_t         sb[$];
    st_t         e;
    st_t         o;
    int          total = 0;
    int          bad = 0;

    instruction_fetch_unit #(
        .RESET_PC  (32'h0000_0000),
        .IMEM_DEPTH(128),
        .NOP_INST  (32'h0000_0000)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .jump         (jump),
        .jump_target  (jump_target),
        .imem_inst    (imem_inst),
        .imem_addr    (imem_addr),
        .pc           (pc),
        .if_id_inst   (if_id_inst),
        .if_id_pc4    (if_id_pc4),
        .if_id_valid  (if_id_valid),
        .fetch_fault  (fetch_fault),
        .misalign_err (misalign_err),
        .fetch_count  (fetch_count)
    );

    always #5 clk = ~clk;

    // Out-of-range reads return a recognisable non-NOP word.
    assign imem_inst = (imem_addr < 32'd128) ? mem[imem_addr[6:0]] : 32'hDEAD_BEEF;

    function automatic st_t obs();
        st_t s;
        s.pc    = pc;
        s.inst  = if_id_inst;
        s.pc4   = if_id_valid ? if_id_pc4 : 32'h0;
        s.cnt   = fetch_count;
        s.valid = if_id_valid;
        s.fault = fetch_fault;
        s.mis   = misalign_err;
        return s;
    endfunction

    function automatic st_t mk(input logic [31:0] p, input logic [31:0] i, input logic [31:0] p4,
                               input logic [31:0] c, input logic v, input logic f, input logic m);
        st_t s;
        s.pc    = p;
        s.inst  = i;
        s.pc4   = v ? p4 : 32'h0;
        s.cnt   = c;
        s.valid = v;
        s.fault = f;
        s.mis   = m;
        return s;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        o = obs();
        e = mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL reset_state got=%h exp=%h", o, e);
        end
        total++;
        if (imem_addr !== 32'h0) begin
            bad++;
            $display("FAIL reset_imem_addr got=%h exp=%h", imem_addr, 32'h0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_sequential();
        sb.push_back(mk(32'd4, 32'h0062_0820, 32'd4, 32'd1, 1'b1, 1'b0, 1'b0));
        sb.push_back(mk(32'd8, 32'h0145_4822, 32'd8, 32'd2, 1'b1, 1'b0, 1'b0));
        for (int k = 0; k < 2; k++) begin
            tick();
            e = sb.pop_front();
            o = obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL sequential_%0d got=%h exp=%h", k, o, e);
            end
        end
        total++;
        if (imem_addr !== 32'd2) begin
            bad++;
            $display("FAIL seq_imem_addr got=%h exp=%h", imem_addr, 32'd2);
        end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int k = 0; k < 3; k++) begin
            sb.push_back(mk(32'd8, 32'h0145_4822, 32'd8, 32'd2, 1'b1, 1'b0, 1'b0));
            tick();
            e = sb.pop_front();
            o = obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL stall_hold_%0d got=%h exp=%h", k, o, e);
            end
        end
        stall = 1'b0;
        sb.push_back(mk(32'd12, mem[2], 32'd12, 32'd3, 1'b1, 1'b0, 1'b0));
        tick();
        e = sb.pop_front();
        o = obs();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL stall_release got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_redirect_priority();
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        stall         = 1'b1;
        jump          = 1'b1;
        jump_target   = 32'h80;
        sb.push_back(mk(32'h40, 32'h0, 32'h0, 32'd3, 1'b0, 1'b0, 1'b0));
        tick();
        branch_taken = 1'b0;
        stall        = 1'b0;
        jump         = 1'b0;
        e = sb.pop_front();
        o = obs();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL branch_over_jump got=%h exp=%h", o, e);
        end
        sb.push_back(mk(32'h44, mem[16], 32'h44, 32'd4, 1'b1, 1'b0, 1'b0));
        tick();
        e = sb.pop_front();
        o = obs();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL branch_refetch got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_misalign_jump();
        jump        = 1'b1;
        jump_target = 32'h0000_0022;
        sb.push_back(mk(32'h20, 32'h0, 32'h0, 32'd4, 1'b0, 1'b0, 1'b1));
        tick();
        jump = 1'b0;
        e = sb.pop_front();
        o = obs();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL misalign_jump got=%h exp=%h", o, e);
        end
        sb.push_back(mk(32'h24, mem[8], 32'h24, 32'd5, 1'b1, 1'b0, 1'b1));
        sb.push_back(mk(32'h28, mem[9], 32'h28, 32'd6, 1'b1, 1'b0, 1'b1));
        for (int k = 0; k < 2; k++) begin
            tick();
            e = sb.pop_front();
            o = obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL misalign_sticky_%0d got=%h exp=%h", k, o, e);
            end
        end
    endtask

    task automatic test_fault();
        logic [31:0] c;
        c = 32'd6;
        for (int unsigned w = 10; w < 128; w++) begin
            c = c + 32'd1;
            sb.push_back(mk((w + 1) * 4, mem[w], (w + 1) * 4, c, 1'b1, 1'b0, 1'b1));
            tick();
            e = sb.pop_front();
            o = obs();
            total++;
            if (o !== e) begin
                bad++;
                $display("FAIL run_word_%0d got=%h exp=%h", w, o, e);
            end
        end
        sb.push_back(mk(32'd512, 32'h0, 32'h0, 32'd124, 1'b0, 1'b1, 1'b1));
        tick();
        e = sb.pop_front();
        o = obs();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL fault_entry got=%h exp=%h", o, e);
        end
        branch_taken  = 1'b1;
        branch_target = 32'h40;
        sb.push_back(mk(32'd512, 32'h0, 32'h0, 32'd124, 1'b0, 1'b1, 1'b1));
        tick();
        e = sb.pop_front();
        o = obs();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL fault_ignores_branch got=%h exp=%h", o, e);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst_n = 1'b0;
        #1;
        o = obs();
        e = mk(32'h0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL async_reset got=%h exp=%h", o, e);
        end
        branch_taken = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(mk(32'd4, 32'h0062_0820, 32'd4, 32'd1, 1'b1, 1'b0, 1'b0));
        tick();
        e = sb.pop_front();
        o = obs();
        total++;
        if (o !== e) begin
            bad++;
            $display("FAIL restart_after_reset got=%h exp=%h", o, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 128; i++) begin
            mem[i] = 32'hC0DE_0000 | i;
        end
        mem[0] = 32'h0062_0820;
        mem[1] = 32'h0145_4822;
        test_reset();
        test_sequential();
        test_stall();
        test_redirect_priority();
        test_misalign_jump();
        test_fault();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Fetch stage of the 32-bit MIPS pipeline. Holds the program counter and drives the word address into the instruction memory.
- Instruction memory has a combinational read (128 words, word-indexed). The returned word is captured, together with PC+4, into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with IF/ID flush, out-of-range fetch fault, and a retired-fetch counter for debug.

Parameters:
- RESET_PC, 32'h0000_0000: byte address loaded into PC on reset.
- IMEM_DEPTH, 128: number of instruction-memory words. A word index >= IMEM_DEPTH is out of range.
- NOP_INST, 32'h0000_0000: bubble word inserted into IF/ID on flush or invalid fetch.

Ports:
- clk, input, 1: rising-edge clock.
- rst_n, input, 1: asynchronous active-low reset.
- stall, input, 1: hazard stall from ID; hold PC and IF/ID.
- branch_taken, input, 1: resolved taken branch from EX.
- branch_target, input, 32: byte target for the branch.
- jump, input, 1: jump from ID.
- jump_target, input, 32: byte target for the jump.
- imem_inst, input, 32: instruction word returned combinationally by instruction memory.
- imem_addr, output, 32: word index to instruction memory, equal to {2'b00, pc[31:2]}.
- pc, output, 32: current byte PC.
- if_id_inst, output, 32: latched instruction.
- if_id_pc4, output, 32: latched PC+4 of that instruction.
- if_id_valid, output, 1: IF/ID holds a real instruction.
- fetch_fault, output, 1: sticky; a fetch was attempted out of range.
- misalign_err, output, 1: sticky; a redirect target had nonzero bits [1:0].
- fetch_count, output, 32: number of valid instructions latched into IF/ID.

Behaviour:
- Reset (asynchronous, on rst_n low):
  - pc = RESET_PC, if_id_inst = NOP_INST, if_id_pc4 = 0.
  - if_id_valid = 0, fetch_fault = 0, misalign_err = 0, fetch_count = 0.
  - Release is synchronous to the next clk edge; the first fetch uses RESET_PC.
- imem_addr is combinational from pc. The instruction is available in the same cycle and is captured at the next rising edge. Fetch-to-IF/ID latency is 1 cycle.
- Next-state selection, evaluated each rising edge, highest priority first:
  1. fetch_fault = 1: pc holds, IF/ID loads a bubble (NOP_INST, valid 0), counter holds. This is a terminal state; only reset clears it.
  2. branch_taken: pc = {branch_target[31:2], 2'b00}, IF/ID flushed to a bubble. Stall and jump are ignored.
  3. jump: pc = {jump_target[31:2], 2'b00}, IF/ID flushed to a bubble. Stall is ignored.
  4. stall: pc, if_id_inst, if_id_pc4, if_id_valid and fetch_count all hold.
  5. Otherwise: pc = pc + 4 (wraps modulo 2^32), if_id_inst = imem_inst, if_id_pc4 = pc + 4, if_id_valid = 1, fetch_count + 1.
- Out of range: in case 5, if pc[31:2] >= IMEM_DEPTH, then:
  - do not latch imem_inst; load a bubble instead;
  - set fetch_fault and freeze pc at the offending value;
  - do not increment fetch_count.
- Misalignment: when a redirect is accepted (case 2 or 3) and the selected target has [1:0] != 0, set misalign_err. The PC is still force-aligned. The flag is sticky until reset.
- A simultaneous branch_taken and jump resolves to the branch target; the jump is discarded.
- fetch_count wraps from 32'hFFFF_FFFF to 0.
- Reset asserted mid-stall or mid-redirect: all state returns to reset values immediately, independent of clk.

Test Plan:
- Reset, then run with IMEM[0] = 32'h00620820 and IMEM[1] = 32'h01454822. After edge 1: if_id_inst = 32'h00620820, if_id_pc4 = 4, valid = 1, pc = 4. After edge 2: if_id_inst = 32'h01454822, pc = 8, fetch_count = 2.
- Stall high for 3 cycles at pc = 8: pc, IF/ID and fetch_count stay unchanged. Deassert stall: next edge gives pc = 12 and fetch_count + 1.
- branch_taken = 1, branch_target = 32'h40, with stall = 1 and jump = 1 (jump_target = 32'h80) in the same cycle: next edge gives pc = 32'h40, if_id_valid = 0, if_id_inst = 0. The following edge latches IMEM[16].
- jump = 1 with jump_target = 32'h0000_0022: pc = 32'h20, misalign_err = 1. Subsequent fetches are normal and misalign_err remains 1.
- Run sequentially to pc = 508 (word 127), then 512: word 127 is latched valid. At pc = 512, fetch_fault = 1, if_id_valid = 0, pc stays 512. A following branch_taken is ignored.
- Assert rst_n low asynchronously between edges during a fault: all outputs return to reset values before the next edge, and fetching restarts at RESET_PC.
